inst_fetch_ras: RTL and testbench
=================================

Name: inst_fetch_ras

Overview:
Parametrised program-counter / instruction-fetch unit for the CSE141L core, with richer control flow than the basic PC block.
Adds absolute or PC-relative targets, call/return through an internal return-address stack (RAS), pipeline stall and sticky halt.
Sits between the control decoder / ALU zero flag and the instruction ROM address input.

Parameters:
T, 10, PC width in bits (instruction ROM address size)
W, 8, target field width; legal range 2 <= W <= T
D, 4, RAS depth in entries; D >= 1
SW, $clog2(D+1), width of the stack-depth output (derived; not overridden)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Stall  input  1  hold all state this cycle
Done  input  1  halt request from control
BrOp  input  3  0=none, 1=always, 2=branch-if-zero, 3=branch-if-nonzero, 4=call, 5=return, 6/7=treated as none
Zero  input  1  ALU zero flag
TgtRel  input  1  1: Target is signed offset from PC; 0: Target is absolute, zero-extended
Target  input  W  jump target or offset
ProgCtr  output  T  current PC, registered
ProgCtr_p1  output  T  ProgCtr+1 mod 2^T, combinational (link value)
Taken  output  1  combinational; high when this cycle's BrOp redirects the PC
StackDepth  output  SW  number of valid RAS entries, registered
StackErr  output  1  sticky overflow/underflow flag, registered
Halted  output  1  sticky halt flag, registered

Behaviour:
- Reset (synchronous): ProgCtr=0, StackDepth=0, StackErr=0, Halted=0. RAS contents are don't-care. Reset overrides every other input.
- Per-edge priority: Reset > Halted > Stall > Done > BrOp.
- Halted=1: all state frozen; Taken=0. Only Reset clears it.
- Stall=1, not halted: all state frozen; Taken=0; Done is ignored this cycle.
- Done=1, not stalled: Halted<=1; PC holds; any BrOp this cycle is ignored; Taken=0.
- Target resolution (tgt):
  - TgtRel=0: zero-extend Target to T bits.
  - TgtRel=1: ProgCtr + sign-extend(Target), modulo 2^T.
- Sequential increment: ProgCtr+1 modulo 2^T (0x3FF -> 0x000 at T=10).
- BrOp=0 or 6/7: PC <= PC+1.
- BrOp=1: PC <= tgt.
- BrOp=2: PC <= tgt if Zero=1, else PC+1.
- BrOp=3: PC <= tgt if Zero=0, else PC+1.
- BrOp=4 (call):
  - StackDepth<D: push PC+1 to RAS[StackDepth]; StackDepth++; PC <= tgt.
  - Stack full: overflow; StackErr<=1; no push; PC <= PC+1.
- BrOp=5 (return):
  - StackDepth>0: PC <= RAS[StackDepth-1]; StackDepth--. The target is always the RAS top; Target/TgtRel are ignored.
  - Stack empty: underflow; StackErr<=1; PC <= PC+1.
- Taken=1 exactly when the PC is loaded from tgt or the RAS. It is 0 for an untaken conditional, an overflow or underflow, a stall, Done, or halt.
- Latency: redirect is visible on ProgCtr the cycle after BrOp is presented; no delay slots.
- StackErr is set only by overflow or underflow and cleared only by Reset.

Test Plan:
- Sequential: Reset, then 5 cycles BrOp=0 -> ProgCtr 0,1,2,3,4,5; StackDepth=0; Taken=0 throughout.
- Relative conditional: PC=5, BrOp=2, Zero=1, TgtRel=1, Target=0xFD -> Taken=1, next PC=2. Same at PC=5 with Zero=0 -> PC=6, Taken=0.
- Nested call/return with absolute targets:
  - PC=3, call 0x40 -> PC=0x40, depth 1.
  - At PC=0x41, call 0x80 -> PC=0x80, depth 2.
  - return -> PC=0x42, depth 1.
  - return -> PC=0x004, depth 0.
- Overflow/underflow, D=4:
  - Four calls fill the stack; the 5th call at PC=0x90 -> PC=0x91, StackErr=1, depth stays 4, Taken=0.
  - After Reset, return at PC=0 -> PC=1, StackErr=1.
- Stall/halt:
  - PC=7, Stall=1 with BrOp=1 -> PC stays 7, Taken=0.
  - Done=1 -> Halted=1, PC stays 7.
  - Subsequent BrOp=1 Target=0x20 -> PC remains 7.
  - Reset -> PC=0, Halted=0.
- Wrap: PC=0x3FF with BrOp=0 -> PC=0x000. PC=2, BrOp=1, TgtRel=1, Target=0x80 -> PC=0x382.

Source files
------------

// File: rtl/inst_fetch_ras_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_ras_if
//   Bundles the control-side inputs and the fetch-side outputs of the
//   instruction-fetch unit.
//   Parameters: T (PC width), W (target width), D (RAS depth).
//   master : drives Stall, Done, BrOp, Zero, TgtRel and Target. It observes
//            ProgCtr, ProgCtr_p1, Taken, StackDepth, StackErr and Halted.
//   slave  : the fetch unit itself, with the opposite directions.
// ---------------------------------------------------------------------------
interface inst_fetch_ras_if #(
    parameter int T = 10,
    parameter int W = 8,
    parameter int D = 4
);
    localparam int SW = $clog2(D + 1);

    logic          Stall;
    logic          Done;
    logic [2:0]    BrOp;
    logic          Zero;
    logic          TgtRel;
    logic [W-1:0]  Target;

    logic [T-1:0]  ProgCtr;
    logic [T-1:0]  ProgCtr_p1;
    logic          Taken;
    logic [SW-1:0] StackDepth;
    logic          StackErr;
    logic          Halted;

    modport master (
        output Stall, Done, BrOp, Zero, TgtRel, Target,
        input  ProgCtr, ProgCtr_p1, Taken, StackDepth, StackErr, Halted
    );

    modport slave (
        input  Stall, Done, BrOp, Zero, TgtRel, Target,
        output ProgCtr, ProgCtr_p1, Taken, StackDepth, StackErr, Halted
    );
endinterface

// File: rtl/inst_fetch_ras.sv
// ---------------------------------------------------------------------------
// inst_fetch_ras
//   Program counter and instruction-fetch unit. Supports:
//     - absolute or PC-relative targets
//     - conditional branches on the ALU zero flag
//     - call and return through an internal return-address stack (RAS)
//     - stall and a sticky halt
//   Ports:
//     Clk    : rising-edge clock
//     Reset  : synchronous, active-high. It overrides every other input.
//     bus    : inst_fetch_ras_if.slave
//              inputs : Stall, Done, BrOp, Zero, TgtRel, Target
//              outputs: ProgCtr, ProgCtr_p1, Taken, StackDepth,
//                       StackErr, Halted
//   BrOp encoding:
//     0 = sequential, 1 = jump, 2 = branch if zero, 3 = branch if non-zero,
//     4 = call, 5 = return, 6/7 = sequential
// ---------------------------------------------------------------------------
module inst_fetch_ras #(
    parameter int T = 10,
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    inst_fetch_ras_if.slave      bus
);
    localparam int SW = $clog2(D + 1);
    // The RAS index needs at least one bit. The array is rounded up to a
    // power of two, so a truncated depth value always addresses a real entry.
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int NE = 1 << IW;

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BZ   = 3'd2;
    localparam logic [2:0] OP_BNZ  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    logic [T-1:0]  r_pc;
    logic [SW-1:0] r_depth;
    logic          r_err;
    logic          r_halted;
    logic [T-1:0]  r_ras [NE];

    logic [T-1:0]  w_pc_p1;
    logic [T-1:0]  w_tgt;
    logic [T-1:0]  w_next_pc;
    logic          w_active;
    logic          w_taken;
    logic          w_push;
    logic          w_pop;
    logic          w_set_err;
    logic          w_full;
    logic          w_empty;
    logic [IW-1:0] w_push_idx;
    logic [IW-1:0] w_top_idx;

    // Absolute targets are zero-extended. Relative targets are sign-extended
    // offsets from the current PC, wrapping modulo 2^T.
    function automatic logic [T-1:0] resolve_tgt(input logic [T-1:0] pc,
                                                 input logic         rel,
                                                 input logic [W-1:0] tgt);
        logic signed [T-1:0] off;
        off = T'($signed(tgt));
        if (rel)
            return pc + off;
        else
            return T'(tgt);
    endfunction

    assign w_pc_p1    = r_pc + T'(1);
    assign w_tgt      = resolve_tgt(r_pc, bus.TgtRel, bus.Target);
    assign w_full     = (r_depth == SW'(D));
    assign w_empty    = (r_depth == '0);
    assign w_push_idx = IW'(r_depth);
    assign w_top_idx  = IW'(r_depth - SW'(1));

    // BrOp only acts when nothing of higher priority claims the cycle.
    assign w_active = !Reset && !r_halted && !bus.Stall && !bus.Done;

    always_comb begin
        w_next_pc = w_pc_p1;
        w_taken   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_err = 1'b0;
        if (w_active) begin
            case (bus.BrOp)
                OP_JMP: begin
                    w_next_pc = w_tgt;
                    w_taken   = 1'b1;
                end
                OP_BZ: begin
                    if (bus.Zero) begin
                        w_next_pc = w_tgt;
                        w_taken   = 1'b1;
                    end
                end
                OP_BNZ: begin
                    if (!bus.Zero) begin
                        w_next_pc = w_tgt;
                        w_taken   = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (w_full) begin
                        w_set_err = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_next_pc = w_tgt;
                        w_taken   = 1'b1;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_set_err = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        w_next_pc = r_ras[w_top_idx];
                        w_taken   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc     <= '0;
            r_depth  <= '0;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
        end else if (!r_halted && !bus.Stall) begin
            if (bus.Done) begin
                r_halted <= 1'b1;
            end else begin
                r_pc <= w_next_pc;
                if (w_push)
                    r_depth <= r_depth + SW'(1);
                else if (w_pop)
                    r_depth <= r_depth - SW'(1);
                if (w_set_err)
                    r_err <= 1'b1;
            end
        end
    end

    // The stack storage is not reset. Entries above StackDepth are never read.
    always_ff @(posedge Clk) begin
        if (w_push)
            r_ras[w_push_idx] <= w_pc_p1;
    end

    assign bus.ProgCtr    = r_pc;
    assign bus.ProgCtr_p1 = w_pc_p1;
    assign bus.Taken      = w_taken;
    assign bus.StackDepth = r_depth;
    assign bus.StackErr   = r_err;
    assign bus.Halted     = r_halted;
endmodule

// File: tb/tb_inst_fetch_ras.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ras
//   The driver applies one directed vector per clock and queues the
//   hand-computed response. The monitor pops each entry. At the falling edge
//   it checks the combinational outputs, and just after the rising edge it
//   checks the registered state.
// ---------------------------------------------------------------------------
module tb_inst_fetch_ras;
    localparam int T = 10;
    localparam int W = 8;
    localparam int D = 4;

    typedef struct {
        string       name;
        int          pcb;      // expected PC before the edge, -1 = unchecked
        logic        tk;
        logic [9:0]  pca;
        logic [2:0]  dep;
        logic        err;
        logic        hlt;
    } exp_t;

    logic clk;
    logic rst;
    inst_fetch_ras_if #(.T(T), .W(W), .D(D)) bus ();

    inst_fetch_ras #(.T(T), .W(W), .D(D)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;
    int   n_issued;
    int   n_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.pcb >= 0) begin
                    chk({e.name, " pc_before"}, 32'(bus.ProgCtr), 32'(e.pcb));
                    chk({e.name, " pc_p1"}, 32'(bus.ProgCtr_p1), 32'((e.pcb + 1) % 1024));
                end
                chk({e.name, " taken"}, 32'(bus.Taken), 32'(e.tk));
                @(posedge clk);
                #1;
                chk({e.name, " pc"}, 32'(bus.ProgCtr), 32'(e.pca));
                chk({e.name, " depth"}, 32'(bus.StackDepth), 32'(e.dep));
                chk({e.name, " err"}, 32'(bus.StackErr), 32'(e.err));
                chk({e.name, " halt"}, 32'(bus.Halted), 32'(e.hlt));
                n_done++;
            end
        end
    end

    // One vector is applied per cycle, #2 after the rising edge.
    task automatic step(input string name, input logic r, input logic st, input logic dn,
                        input logic [2:0] op, input logic z, input logic rel,
                        input logic [7:0] tg, input int pcb, input logic tk,
                        input logic [9:0] pca, input logic [2:0] dep,
                        input logic err, input logic hlt);
        exp_t e;
        rst        = r;
        bus.Stall  = st;
        bus.Done   = dn;
        bus.BrOp   = op;
        bus.Zero   = z;
        bus.TgtRel = rel;
        bus.Target = tg;
        e.name = name; e.pcb = pcb; e.tk = tk; e.pca = pca;
        e.dep = dep; e.err = err; e.hlt = hlt;
        q.push_back(e);
        n_issued++;
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_issued = 0; n_done = 0;
        rst = 1'b1;
        bus.Stall = 0; bus.Done = 0; bus.BrOp = 0; bus.Zero = 0;
        bus.TgtRel = 0; bus.Target = 0;
        repeat (2) @(posedge clk);
        #2;
        //    name       rst st dn op z rel tgt    pcb  tk pca    dep err hlt
        step("reset",    1, 0, 0, 0, 0, 0, 8'h00, -1,   0, 10'h000, 0, 0, 0);
        step("seq1",     0, 0, 0, 0, 0, 0, 8'h00, 0,    0, 10'h001, 0, 0, 0);
        step("seq2",     0, 0, 0, 0, 0, 0, 8'h00, 1,    0, 10'h002, 0, 0, 0);
        step("seq3",     0, 0, 0, 0, 0, 0, 8'h00, 2,    0, 10'h003, 0, 0, 0);
        step("seq4",     0, 0, 0, 0, 0, 0, 8'h00, 3,    0, 10'h004, 0, 0, 0);
        step("seq5",     0, 0, 0, 0, 0, 0, 8'h00, 4,    0, 10'h005, 0, 0, 0);
        step("bz_rel",   0, 0, 0, 2, 1, 1, 8'hFD, 5,    1, 10'h002, 0, 0, 0);
        step("jmp_abs",  0, 0, 0, 1, 0, 0, 8'h05, 2,    1, 10'h005, 0, 0, 0);
        step("bz_untk",  0, 0, 0, 2, 0, 1, 8'hFD, 5,    0, 10'h006, 0, 0, 0);
        step("bnz_tk",   0, 0, 0, 3, 0, 0, 8'h03, 6,    1, 10'h003, 0, 0, 0);
        step("call40",   0, 0, 0, 4, 0, 0, 8'h40, 3,    1, 10'h040, 1, 0, 0);
        step("seq40",    0, 0, 0, 0, 0, 0, 8'h00, 'h40, 0, 10'h041, 1, 0, 0);
        step("call80",   0, 0, 0, 4, 0, 0, 8'h80, 'h41, 1, 10'h080, 2, 0, 0);
        step("ret1",     0, 0, 0, 5, 0, 1, 8'h11, 'h80, 1, 10'h042, 1, 0, 0);
        step("ret2",     0, 0, 0, 5, 0, 0, 8'h77, 'h42, 1, 10'h004, 0, 0, 0);
        step("fill1",    0, 0, 0, 4, 0, 0, 8'h10, 4,    1, 10'h010, 1, 0, 0);
        step("fill2",    0, 0, 0, 4, 0, 0, 8'h20, 'h10, 1, 10'h020, 2, 0, 0);
        step("fill3",    0, 0, 0, 4, 0, 0, 8'h30, 'h20, 1, 10'h030, 3, 0, 0);
        step("fill4",    0, 0, 0, 4, 0, 0, 8'h90, 'h30, 1, 10'h090, 4, 0, 0);
        step("ovf",      0, 0, 0, 4, 0, 0, 8'h50, 'h90, 0, 10'h091, 4, 1, 0);
        step("ret_top",  0, 0, 0, 5, 0, 0, 8'h00, 'h91, 1, 10'h031, 3, 1, 0);
        step("ret_nxt",  0, 0, 0, 5, 0, 0, 8'h00, 'h31, 1, 10'h021, 2, 1, 0);
        step("reset2",   1, 0, 0, 5, 0, 0, 8'h00, 'h21, 0, 10'h000, 0, 0, 0);
        step("unf",      0, 0, 0, 5, 0, 0, 8'h00, 0,    0, 10'h001, 0, 1, 0);
        step("bnz_untk", 0, 0, 0, 3, 1, 0, 8'h40, 1,    0, 10'h002, 0, 1, 0);
        step("jmp7",     0, 0, 0, 1, 0, 0, 8'h07, 2,    1, 10'h007, 0, 1, 0);
        step("stall",    0, 1, 0, 1, 0, 0, 8'h20, 7,    0, 10'h007, 0, 1, 0);
        step("stall_dn", 0, 1, 1, 1, 0, 0, 8'h20, 7,    0, 10'h007, 0, 1, 0);
        step("done",     0, 0, 1, 1, 0, 0, 8'h20, 7,    0, 10'h007, 0, 1, 1);
        step("halt_jmp", 0, 0, 0, 1, 0, 0, 8'h20, 7,    0, 10'h007, 0, 1, 1);
        step("halt_cal", 0, 0, 0, 4, 0, 0, 8'h20, 7,    0, 10'h007, 0, 1, 1);
        step("reset3",   1, 0, 0, 0, 0, 0, 8'h00, 7,    0, 10'h000, 0, 0, 0);
        step("rel_neg",  0, 0, 0, 1, 0, 1, 8'hFF, 0,    1, 10'h3FF, 0, 0, 0);
        step("wrap",     0, 0, 0, 0, 0, 0, 8'h00, 'h3FF,0, 10'h000, 0, 0, 0);
        step("jmp2",     0, 0, 0, 1, 0, 0, 8'h02, 0,    1, 10'h002, 0, 0, 0);
        step("rel_80",   0, 0, 0, 1, 0, 1, 8'h80, 2,    1, 10'h382, 0, 0, 0);
        step("abs_zx",   0, 0, 0, 1, 0, 0, 8'hFF, 'h382,1, 10'h0FF, 0, 0, 0);
        step("op6",      0, 0, 0, 6, 1, 0, 8'h10, 'h0FF,0, 10'h100, 0, 0, 0);
        step("op7",      0, 0, 0, 7, 1, 0, 8'h10, 'h100,0, 10'h101, 0, 0, 0);
        bus.BrOp = 0;
        for (int i = 0; i < 50 && n_done < n_issued; i++) @(posedge clk);
        #3;
        n_cmp++;
        if (n_done != n_issued) begin
            n_bad++;
            $display("FAIL drain: %0d vectors checked, %0d issued", n_done, n_issued);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
